// File: rtl/trdb_itype_classifier.sv
// rtl/trdb_itype_classifier.sv - registered stream classifier for retired instruction types
//
// Holds the most recent retired instruction pending until its successor
// retires (or a flush ends the stream), then emits a registered
// classification of the pending instruction.
//
// Optional feature macro: TRDB_COMPRESSED_JUMP_EN (C.JR / C.JALR count as JALR).
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   valid_i                one instruction retires this cycle
//   inst_data_i[31:0]      instruction word (compressed in [15:0])
//   compressed_i           instruction is 16-bit
//   iaddr_i[XLEN-1:0]      instruction address
//   exception_i            instruction excepted
//   flush_i                end-of-stream request for the pending instruction
//   valid_o                one-cycle classification pulse
//   iaddr_o[XLEN-1:0]      address of the classified instruction
//   branch_o               conditional branch
//   branch_taken_o         branch taken (0 when not a branch or flushed)
//   updiscon_o             uninferable discontinuity (JALR or exception)
//   exception_o            classified instruction excepted
//   last_o                 emitted without a successor

module trdb_itype_classifier #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [31:0]     inst_data_i,
  input  logic            compressed_i,
  input  logic [XLEN-1:0] iaddr_i,
  input  logic            exception_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic [XLEN-1:0] iaddr_o,
  output logic            branch_o,
  output logic            branch_taken_o,
  output logic            updiscon_o,
  output logic            exception_o,
  output logic            last_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] INC_C = XLEN'(2);
  localparam logic [XLEN-1:0] INC_I = XLEN'(4);

  state_t state_q, state_d;

  // Pending slot. Only the low half of the word takes part in any decode.
  logic [15:0]     p_inst_q;
  logic            p_comp_q;
  logic [XLEN-1:0] p_addr_q;
  logic            p_exc_q;

  logic unused_inst_hi;
  assign unused_inst_hi = ^inst_data_i[31:16];

  logic            emit;
  logic            has_succ;
  logic            capture;
  logic            dec_branch;
  logic            dec_jalr;
  logic            dec_cjump;
  logic [XLEN-1:0] seq_addr;

  always_comb begin
    dec_branch = 1'b0;
    dec_jalr   = 1'b0;
    if (p_comp_q) begin
      dec_branch = (p_inst_q[1:0] == 2'b01) && (p_inst_q[15:14] == 2'b11);
    end else begin
      dec_branch = (p_inst_q[6:0] == 7'b1100011);
      dec_jalr   = (p_inst_q[6:0] == 7'b1100111) && (p_inst_q[14:12] == 3'b000);
    end
  end

`ifdef TRDB_COMPRESSED_JUMP_EN
  // inst[15:13]=100 covers both C.JR (bit12=0) and C.JALR (bit12=1).
  assign dec_cjump = p_comp_q &&
                     (p_inst_q[15:13] == 3'b100) &&
                     (p_inst_q[11:7] != 5'd0) &&
                     (p_inst_q[6:2] == 5'd0) &&
                     (p_inst_q[1:0] == 2'b10);
`else
  assign dec_cjump = 1'b0;
`endif

  // Wraps naturally at 2^XLEN.
  assign seq_addr = p_addr_q + (p_comp_q ? INC_C : INC_I);

  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    has_succ = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (valid_i) begin
          capture = 1'b1;
          state_d = flush_i ? ST_DRAIN : ST_PEND;
        end
      end
      ST_PEND: begin
        if (valid_i) begin
          emit     = 1'b1;
          has_succ = 1'b1;
          capture  = 1'b1;
          state_d  = flush_i ? ST_DRAIN : ST_PEND;
        end else if (flush_i) begin
          emit    = 1'b1;
          state_d = ST_EMPTY;
        end
      end
      ST_DRAIN: begin
        // The pending instruction was flushed when captured; a new input
        // here starts a fresh stream and is not its successor.
        emit = 1'b1;
        if (valid_i) begin
          capture = 1'b1;
          state_d = flush_i ? ST_DRAIN : ST_PEND;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_EMPTY;
      p_inst_q       <= '0;
      p_comp_q       <= 1'b0;
      p_addr_q       <= '0;
      p_exc_q        <= 1'b0;
      valid_o        <= 1'b0;
      iaddr_o        <= '0;
      branch_o       <= 1'b0;
      branch_taken_o <= 1'b0;
      updiscon_o     <= 1'b0;
      exception_o    <= 1'b0;
      last_o         <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_o <= emit;
      if (emit) begin
        iaddr_o        <= p_addr_q;
        branch_o       <= dec_branch;
        branch_taken_o <= has_succ && dec_branch && (seq_addr != iaddr_i);
        updiscon_o     <= dec_jalr || dec_cjump || p_exc_q;
        exception_o    <= p_exc_q;
        last_o         <= !has_succ;
      end
      if (capture) begin
        p_inst_q <= inst_data_i[15:0];
        p_comp_q <= compressed_i;
        p_addr_q <= iaddr_i;
        p_exc_q  <= exception_i;
      end
    end
  end

endmodule

// File: tb/tb_trdb_itype_classifier.sv
// tb/tb_trdb_itype_classifier.sv - self-checking bench for trdb_itype_classifier

module tb_trdb_itype_classifier;

  localparam int XLEN = 32;
`ifdef TRDB_COMPRESSED_JUMP_EN
  localparam bit CJ_EN = 1'b1;
`else
  localparam bit CJ_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid = 1'b0;
  logic [31:0]     inst = '0;
  logic            comp = 1'b0;
  logic [XLEN-1:0] iaddr = '0;
  logic            exc = 1'b0;
  logic            flush = 1'b0;
  logic            valid_o;
  logic [XLEN-1:0] iaddr_o;
  logic            branch_o, branch_taken_o, updiscon_o, exception_o, last_o;

  int n_checks = 0;
  int n_errors = 0;

  trdb_itype_classifier #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .inst_data_i(inst),
    .compressed_i(comp), .iaddr_i(iaddr), .exception_i(exc), .flush_i(flush),
    .valid_o(valid_o), .iaddr_o(iaddr_o), .branch_o(branch_o),
    .branch_taken_o(branch_taken_o), .updiscon_o(updiscon_o),
    .exception_o(exception_o), .last_o(last_o)
  );

  always #5 clk = ~clk;

  // Reference model: a 0/1-entry pending list where each entry remembers
  // whether a flush was already requested for it.
  typedef struct {
    logic [31:0]     inst;
    bit              comp;
    logic [XLEN-1:0] addr;
    bit              exc;
    bit              flushed;
  } pend_t;
  pend_t pend_q[$];

  bit              e_valid, e_br, e_tk, e_up, e_ex, e_last;
  logic [XLEN-1:0] e_addr;

  function automatic bit m_is_branch(logic [31:0] i, bit c);
    if (c) return (i[1:0] == 2'b01) && (i[15:13] == 3'b110 || i[15:13] == 3'b111);
    return i[6:0] == 7'h63;
  endfunction

  function automatic bit m_is_jump(logic [31:0] i, bit c);
    if (!c) return (i[6:0] == 7'h67) && (i[14:12] == 3'd0);
    return CJ_EN && (i[15:12] == 4'h8 || i[15:12] == 4'h9) &&
           (i[11:7] != 5'd0) && (i[6:2] == 5'd0) && (i[1:0] == 2'b10);
  endfunction

  task automatic model_cycle(input bit r, input bit v, input logic [31:0] i, input bit c,
                             input logic [XLEN-1:0] a, input bit x, input bit f);
    pend_t p, n;
    longint unsigned nxt;
    bit succ;
    if (r) begin
      pend_q.delete();
      e_valid = 0; e_addr = '0; e_br = 0; e_tk = 0; e_up = 0; e_ex = 0; e_last = 0;
      return;
    end
    e_valid = 0;
    if (pend_q.size() != 0) begin
      p = pend_q[0];
      if (p.flushed || v || f) begin
        succ    = !p.flushed && v;
        nxt     = (longint'(p.addr) + (p.comp ? 2 : 4)) % (64'd1 << XLEN);
        e_valid = 1;
        e_addr  = p.addr;
        e_br    = m_is_branch(p.inst, p.comp);
        e_tk    = succ && e_br && (nxt != longint'(a));
        e_up    = m_is_jump(p.inst, p.comp) || p.exc;
        e_ex    = p.exc;
        e_last  = !succ;
        void'(pend_q.pop_front());
      end
    end
    if (v) begin
      n.inst = i; n.comp = c; n.addr = a; n.exc = x; n.flushed = f;
      pend_q.push_back(n);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [31:0] i, input bit c,
                      input logic [XLEN-1:0] a, input bit x, input bit f);
    rst = r; valid = v; inst = i; comp = c; iaddr = a; exc = x; flush = f;
    @(posedge clk);
    model_cycle(r, v, i, c, a, x, f);
    #1;
    check("valid_o", 64'(valid_o), 64'(e_valid));
    check("iaddr_o", 64'(iaddr_o), 64'(e_addr));
    check("branch_o", 64'(branch_o), 64'(e_br));
    check("branch_taken_o", 64'(branch_taken_o), 64'(e_tk));
    check("updiscon_o", 64'(updiscon_o), 64'(e_up));
    check("exception_o", 64'(exception_o), 64'(e_ex));
    check("last_o", 64'(last_o), 64'(e_last));
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, '0, 0, 0);
  endtask

  typedef struct {
    string           name;
    logic [31:0]     a_inst;
    bit              a_comp;
    logic [XLEN-1:0] a_addr;
    bit              a_exc;
    bit              b_valid;
    logic [XLEN-1:0] b_addr;
    bit              b_flush;
    bit              x_br, x_tk, x_up, x_ex, x_last;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  localparam int NP = 13;
  logic [31:0] pool[NP];
  bit          pool_c[NP];

  initial begin
    vecs[0] = '{"beq_seq",    32'h0000_0063, 0, 32'h100, 0, 1, 32'h104, 0, 1, 0, 0, 0, 0};
    vecs[1] = '{"cbnez_tkn",  32'h0000_E001, 1, 32'h200, 0, 1, 32'h240, 0, 1, 1, 0, 0, 0};
    vecs[2] = '{"cbnez_seq",  32'h0000_E001, 1, 32'h200, 0, 1, 32'h202, 0, 1, 0, 0, 0, 0};
    vecs[3] = '{"jalr_flush", 32'h0000_8067, 0, 32'h300, 0, 0, 32'h0,   1, 0, 0, 1, 0, 1};
    vecs[4] = '{"add_exc",    32'h0000_0033, 0, 32'h400, 1, 1, 32'h1C0, 0, 0, 0, 1, 1, 0};
    vecs[5] = '{"bne_wrap",   32'h0000_1063, 0, 32'hFFFF_FFFC, 0, 1, 32'h0, 0, 1, 0, 0, 0, 0};
    vecs[6] = '{"beq_tkn",    32'h0000_0063, 0, 32'h100, 0, 1, 32'h200, 0, 1, 1, 0, 0, 0};
    vecs[7] = '{"cjr",        32'h0000_8082, 1, 32'h500, 0, 1, 32'h600, 0, 0, 0, CJ_EN, 0, 0};
    vecs[8] = '{"jalr_f3",    32'h0000_9067, 0, 32'h300, 0, 1, 32'h304, 0, 0, 0, 0, 0, 0};
    vecs[9] = '{"br_flush",   32'h0000_5063, 0, 32'h700, 0, 0, 32'h0,   1, 1, 0, 0, 0, 1};

    pool[0]  = 32'h0000_0063; pool_c[0]  = 0;  // BEQ
    pool[1]  = 32'h0000_1063; pool_c[1]  = 0;  // BNE
    pool[2]  = 32'h0000_8067; pool_c[2]  = 0;  // JALR
    pool[3]  = 32'h0000_1067; pool_c[3]  = 0;  // 1100111 funct3=1 (not JALR)
    pool[4]  = 32'h0000_0033; pool_c[4]  = 0;  // ADD
    pool[5]  = 32'h0000_006F; pool_c[5]  = 0;  // JAL
    pool[6]  = 32'h0000_E001; pool_c[6]  = 1;  // C.BNEZ
    pool[7]  = 32'h0000_C001; pool_c[7]  = 1;  // C.BEQZ
    pool[8]  = 32'h0000_8082; pool_c[8]  = 1;  // C.JR
    pool[9]  = 32'h0000_9082; pool_c[9]  = 1;  // C.JALR
    pool[10] = 32'h0000_8002; pool_c[10] = 1;  // rs1=0, not a jump
    pool[11] = 32'h0000_0001; pool_c[11] = 1;  // C.NOP
    pool[12] = 32'h0000_A001; pool_c[12] = 1;  // C.J (funct3=101, not a branch)
  end

  initial begin
    logic [XLEN-1:0] next_addr;
    int k;
    logic [31:0] ri;
    bit rc;

    step(1, 0, 32'h0, 0, '0, 0, 0);
    step(1, 0, 32'h0, 0, '0, 0, 0);
    check("reset_valid_o", 64'(valid_o), 64'd0);
    check("reset_iaddr_o", 64'(iaddr_o), 64'd0);

    for (int v = 0; v < NV; v++) begin
      step(1, 0, 32'h0, 0, '0, 0, 0);
      step(0, 1, vecs[v].a_inst, vecs[v].a_comp, vecs[v].a_addr, vecs[v].a_exc, 0);
      check({vecs[v].name, "_early"}, 64'(valid_o), 64'd0);
      step(0, vecs[v].b_valid, 32'h0000_0033, 0, vecs[v].b_addr, 0, vecs[v].b_flush);
      check({vecs[v].name, "_valid"}, 64'(valid_o), 64'd1);
      check({vecs[v].name, "_addr"}, 64'(iaddr_o), 64'(vecs[v].a_addr));
      check({vecs[v].name, "_br"}, 64'(branch_o), 64'(vecs[v].x_br));
      check({vecs[v].name, "_tk"}, 64'(branch_taken_o), 64'(vecs[v].x_tk));
      check({vecs[v].name, "_up"}, 64'(updiscon_o), 64'(vecs[v].x_up));
      check({vecs[v].name, "_ex"}, 64'(exception_o), 64'(vecs[v].x_ex));
      check({vecs[v].name, "_last"}, 64'(last_o), 64'(vecs[v].x_last));
      idle();
      check({vecs[v].name, "_pulse"}, 64'(valid_o), 64'd0);
      check({vecs[v].name, "_hold"}, 64'(iaddr_o), 64'(vecs[v].a_addr));
    end

    // valid+flush in PEND, then reset during DRAIN.
    step(1, 0, 32'h0, 0, '0, 0, 0);
    step(0, 1, 32'h0000_0063, 0, 32'h800, 0, 0);
    step(0, 1, 32'h0000_0063, 0, 32'h900, 0, 1);
    check("pf_valid", 64'(valid_o), 64'd1);
    check("pf_addr", 64'(iaddr_o), 64'h800);
    check("pf_tk", 64'(branch_taken_o), 64'd1);
    check("pf_last", 64'(last_o), 64'd0);
    step(1, 0, 32'h0, 0, '0, 0, 0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_addr", 64'(iaddr_o), 64'd0);
    check("rst_br", 64'(branch_o), 64'd0);
    for (int c = 0; c < 3; c++) begin
      idle();
      check("rst_no_emit", 64'(valid_o), 64'd0);
    end

    // DRAIN with a new valid: the new input is not a successor.
    step(0, 1, 32'h0000_0063, 0, 32'hA00, 0, 1);
    step(0, 1, 32'h0000_0033, 0, 32'hB00, 0, 0);
    check("drain_valid", 64'(valid_o), 64'd1);
    check("drain_addr", 64'(iaddr_o), 64'hA00);
    check("drain_tk", 64'(branch_taken_o), 64'd0);
    check("drain_last", 64'(last_o), 64'd1);
    step(0, 0, 32'h0, 0, '0, 0, 1);
    check("drain2_addr", 64'(iaddr_o), 64'hB00);
    check("drain2_last", 64'(last_o), 64'd1);
    step(0, 0, 32'h0, 0, '0, 0, 1);
    check("empty_flush", 64'(valid_o), 64'd0);

    // Randomised stream against the model.
    next_addr = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      k  = int'($urandom_range(0, NP - 1));
      rc = pool_c[k];
      ri = pool[k];
      if (rc) ri[31:16] = 16'($urandom);
      else    ri = ri | ($urandom & 32'hFFFF_8000);
      if ($urandom_range(0, 99) < 25) next_addr = {$urandom} & ~32'h1;
      if ($urandom_range(0, 99) < 3) next_addr = 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) < 2) begin
        step(1, 0, 32'h0, 0, '0, 0, 0);
      end else if ($urandom_range(0, 99) < 70) begin
        step(0, 1, ri, rc, next_addr, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 15);
        next_addr = next_addr + (rc ? 32'd2 : 32'd4);
      end else begin
        step(0, 0, ri, rc, next_addr, 0, $urandom_range(0, 99) < 40);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
